// File: rtl/available_cell_selector.sv
// -----------------------------------------------------------------------------
// available_cell_selector
//
// Purpose:
//   Picks one free cell for the allocation path, one request at a time. On an
//   accepted request it snapshots the per-cell mark vector (free flag + handle).
//   It then tests one cell per cycle, starting at the start pointer and
//   wrapping around. It reports the first free cell's index and handle, or
//   "array full", on a valid/ready response.
//
// Optional feature (macro SELECTOR_ROUND_ROBIN_EN):
//   Defined   : after a found response is accepted, the next scan starts at
//               the cell after the one just returned (round-robin spreading).
//   Undefined : every scan starts at cell 0 (lowest free index wins).
//
// Ports:
//   clk          in   1                 rising-edge clock
//   reset        in   1                 synchronous active-high reset
//   mark_bool    in   NUM_CELLS         bit i = cell i free
//   mark_value   in   NUM_CELLS*DATA_W  handle of cell i at [i*DATA_W +: DATA_W]
//   req_valid    in   1                 allocation request
//   req_ready    out  1                 high only while idle
//   resp_valid   out  1                 response valid, held until accepted
//   resp_ready   in   1                 consumer accepts response
//   resp_found   out  1                 1 = free cell found, 0 = array full
//   resp_index   out  IDX_W             selected cell index (0 if not found)
//   resp_handle  out  DATA_W            handle of selected cell (0 if not found)
// -----------------------------------------------------------------------------
module available_cell_selector #(
    parameter int NUM_CELLS = 16,
    parameter int DATA_W    = 8,
    parameter int IDX_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CELLS-1:0]          mark_bool,
    input  logic [NUM_CELLS*DATA_W-1:0]   mark_value,
    input  logic                          req_valid,
    output logic                          req_ready,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic                          resp_found,
    output logic [IDX_W-1:0]              resp_index,
    output logic [DATA_W-1:0]             resp_handle
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_CELLS - 1);

    state_t                        state_r,       state_s;
    logic [NUM_CELLS-1:0]          snap_bool_r,   snap_bool_s;
    logic [NUM_CELLS*DATA_W-1:0]   snap_value_r,  snap_value_s;
    logic [IDX_W-1:0]              ptr_r,         ptr_s;
    logic [IDX_W-1:0]              cnt_r,         cnt_s;
    logic                          req_ready_r,   req_ready_s;
    logic                          resp_valid_r,  resp_valid_s;
    logic                          resp_found_r,  resp_found_s;
    logic [IDX_W-1:0]              resp_index_r,  resp_index_s;
    logic [DATA_W-1:0]             resp_handle_r, resp_handle_s;
    logic [IDX_W-1:0]              start_ptr_s;

`ifdef SELECTOR_ROUND_ROBIN_EN
    logic [IDX_W-1:0]              start_ptr_r,   start_ptr_nxt_s;

    // Round-robin start pointer: advance past the cell just handed out.
    always_comb begin
        start_ptr_nxt_s = start_ptr_r;
        if ((state_r == ST_RESP) && resp_valid_r && resp_ready && resp_found_r) begin
            start_ptr_nxt_s = resp_index_r + IDX_W'(1);
        end else begin
            start_ptr_nxt_s = start_ptr_r;
        end
    end

    // Start pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_ptr_r <= '0;
        end else begin
            start_ptr_r <= start_ptr_nxt_s;
        end
    end

    assign start_ptr_s = start_ptr_r;
`else
    assign start_ptr_s = '0;
`endif

    // Next-state and next-output logic for the IDLE/SCAN/RESP controller.
    always_comb begin
        state_s       = state_r;
        snap_bool_s   = snap_bool_r;
        snap_value_s  = snap_value_r;
        ptr_s         = ptr_r;
        cnt_s         = cnt_r;
        resp_found_s  = resp_found_r;
        resp_index_s  = resp_index_r;
        resp_handle_s = resp_handle_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    // Snapshot so later input changes cannot disturb the scan.
                    snap_bool_s  = mark_bool;
                    snap_value_s = mark_value;
                    ptr_s        = start_ptr_s;
                    cnt_s        = '0;
                    state_s      = ST_SCAN;
                end else begin
                    state_s      = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (snap_bool_r[ptr_r]) begin
                    resp_found_s  = 1'b1;
                    resp_index_s  = ptr_r;
                    resp_handle_s = snap_value_r[ptr_r*DATA_W +: DATA_W];
                    state_s       = ST_RESP;
                end else if (cnt_r == LAST_CNT) begin
                    resp_found_s  = 1'b0;
                    resp_index_s  = '0;
                    resp_handle_s = '0;
                    state_s       = ST_RESP;
                end else begin
                    // Pointer wraps naturally through IDX_W truncation.
                    ptr_s = ptr_r + IDX_W'(1);
                    cnt_s = cnt_r + IDX_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_valid_r && resp_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Handshake flags are registered copies of the next state decode.
        req_ready_s  = (state_s == ST_IDLE);
        resp_valid_s = (state_s == ST_RESP);
    end

    // State, snapshot and registered output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            snap_bool_r   <= '0;
            snap_value_r  <= '0;
            ptr_r         <= '0;
            cnt_r         <= '0;
            req_ready_r   <= 1'b1;
            resp_valid_r  <= 1'b0;
            resp_found_r  <= 1'b0;
            resp_index_r  <= '0;
            resp_handle_r <= '0;
        end else begin
            state_r       <= state_s;
            snap_bool_r   <= snap_bool_s;
            snap_value_r  <= snap_value_s;
            ptr_r         <= ptr_s;
            cnt_r         <= cnt_s;
            req_ready_r   <= req_ready_s;
            resp_valid_r  <= resp_valid_s;
            resp_found_r  <= resp_found_s;
            resp_index_r  <= resp_index_s;
            resp_handle_r <= resp_handle_s;
        end
    end

    assign req_ready   = req_ready_r;
    assign resp_valid  = resp_valid_r;
    assign resp_found  = resp_found_r;
    assign resp_index  = resp_index_r;
    assign resp_handle = resp_handle_r;

endmodule

// File: tb/tb_available_cell_selector.sv
// -----------------------------------------------------------------------------
// tb_available_cell_selector
//
// Purpose:
//   Self-checking bench for available_cell_selector. A small reference model
//   computes the expected response (found/index/handle/latency) when each
//   request is driven. It pushes the result to a scoreboard queue, which is
//   popped when the DUT raises resp_valid. Honours SELECTOR_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_available_cell_selector;

    localparam int NUM_CELLS = 16;
    localparam int DATA_W    = 8;
    localparam int IDX_W     = 4;
    localparam int MAX_WAIT  = 40;

    typedef struct {
        logic              found;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] handle;
        int                lat;
    } exp_t;

    logic                        clk;
    logic                        reset;
    logic [NUM_CELLS-1:0]        mark_bool;
    logic [NUM_CELLS*DATA_W-1:0] mark_value;
    logic                        req_valid;
    logic                        req_ready;
    logic                        resp_valid;
    logic                        resp_ready;
    logic                        resp_found;
    logic [IDX_W-1:0]            resp_index;
    logic [DATA_W-1:0]           resp_handle;

    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];
    int   model_start;

    available_cell_selector #(
        .NUM_CELLS (NUM_CELLS),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mark_bool   (mark_bool),
        .mark_value  (mark_value),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_found  (resp_found),
        .resp_index  (resp_index),
        .resp_handle (resp_handle)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk from the model start pointer, first free cell wins.
    function automatic exp_t model_pick(input logic [NUM_CELLS-1:0] b,
                                        input logic [NUM_CELLS*DATA_W-1:0] v);
        exp_t e;
        e.found  = 1'b0;
        e.index  = '0;
        e.handle = '0;
        e.lat    = NUM_CELLS + 1;
        for (int i = 0; i < NUM_CELLS; i++) begin
            int p;
            p = (model_start + i) % NUM_CELLS;
            if (b[p]) begin
                e.found  = 1'b1;
                e.index  = p[IDX_W-1:0];
                e.handle = v[p*DATA_W +: DATA_W];
                e.lat    = i + 2;
                break;
            end
        end
        return e;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_start = 0;
    endtask

    // One request: drive, wait for response, compare, optionally stall, accept.
    task automatic run_req(input logic [NUM_CELLS-1:0] b,
                           input logic [NUM_CELLS*DATA_W-1:0] v,
                           input int hold, input bit scramble, input string tag);
        exp_t e;
        int   cyc;
        sb_q.push_back(model_pick(b, v));
        @(negedge clk);
        mark_bool  = b;
        mark_value = v;
        req_valid  = 1'b1;
        resp_ready = 1'b0;
        cyc = 0;
        @(negedge clk);
        cyc = 1;
        req_valid = 1'b0;
        if (scramble) begin
            mark_bool  = ~b;
            mark_value = ~v;
        end
        while (!resp_valid && cyc < MAX_WAIT) begin
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        if (!resp_valid) begin
            check_value({tag, "_timeout"}, 32'(resp_valid), 32'd1);
            return;
        end
        check_value({tag, "_latency"}, 32'(cyc), 32'(e.lat));
        check_value({tag, "_found"},   32'(resp_found),  32'(e.found));
        check_value({tag, "_index"},   32'(resp_index),  32'(e.index));
        check_value({tag, "_handle"},  32'(resp_handle), 32'(e.handle));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_value({tag, "_hold_valid"},  32'(resp_valid),  32'd1);
            check_value({tag, "_hold_ready"},  32'(req_ready),   32'd0);
            check_value({tag, "_hold_found"},  32'(resp_found),  32'(e.found));
            check_value({tag, "_hold_index"},  32'(resp_index),  32'(e.index));
            check_value({tag, "_hold_handle"}, 32'(resp_handle), 32'(e.handle));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_value({tag, "_post_valid"}, 32'(resp_valid), 32'd0);
        check_value({tag, "_post_ready"}, 32'(req_ready),  32'd1);
`ifdef SELECTOR_ROUND_ROBIN_EN
        if (e.found) model_start = (int'(e.index) + 1) % NUM_CELLS;
`endif
    endtask

    // Main stimulus sequence.
    initial begin
        logic [NUM_CELLS*DATA_W-1:0] v;
        logic [NUM_CELLS-1:0]        b;
        int                          stale;
        n_checks    = 0;
        n_errors    = 0;
        model_start = 0;
        reset       = 1'b1;
        mark_bool   = '0;
        mark_value  = '0;
        req_valid   = 1'b0;
        resp_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_value("rst_req_ready",  32'(req_ready),   32'd1);
        check_value("rst_resp_valid", 32'(resp_valid),  32'd0);
        check_value("rst_found",      32'(resp_found),  32'd0);
        check_value("rst_index",      32'(resp_index),  32'd0);
        check_value("rst_handle",     32'(resp_handle), 32'd0);

        // Cell 0 free: best-case latency.
        v = '0;
        v[0 +: DATA_W] = 8'h2A;
        run_req(16'h0001, v, 0, 1'b0, "cell0");

        // Cell 5 free: five cells skipped.
        v = {NUM_CELLS{8'hC3}};
        v[5*DATA_W +: DATA_W] = 8'h55;
        run_req(16'h0020, v, 0, 1'b0, "cell5");

        // Array full: every cell tested, not found.
        run_req(16'h0000, {NUM_CELLS{8'hEE}}, 0, 1'b0, "full");

        // Stalled response plus inputs changed mid-scan.
        v = {NUM_CELLS{8'h11}};
        v[9*DATA_W +: DATA_W] = 8'h99;
        run_req(16'h0200, v, 5, 1'b1, "hold");

        // Start-pointer behaviour from a clean reset.
        do_reset();
        for (int i = 0; i < NUM_CELLS; i++) v[i*DATA_W +: DATA_W] = 8'(8'h40 + i);
        run_req(16'h8003, v, 0, 1'b0, "rr0");
        run_req(16'h8003, v, 0, 1'b0, "rr1");
        run_req(16'h8003, v, 0, 1'b0, "rr2");

        // Reset during SCAN: abandon request, no stale response afterwards.
        @(negedge clk);
        mark_bool  = 16'h0000;
        req_valid  = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_start = 0;
        check_value("midrst_req_ready",  32'(req_ready),   32'd1);
        check_value("midrst_resp_valid", 32'(resp_valid),  32'd0);
        check_value("midrst_found",      32'(resp_found),  32'd0);
        check_value("midrst_index",      32'(resp_index),  32'd0);
        stale = 0;
        resp_ready = 1'b1;
        repeat (NUM_CELLS + 4) begin
            @(negedge clk);
            if (resp_valid) stale++;
        end
        resp_ready = 1'b0;
        check_value("midrst_no_stale", 32'(stale), 32'd0);

        // Sparse random patterns with random stalls.
        for (int t = 0; t < 8; t++) begin
            b = 16'($urandom) & 16'($urandom) & 16'($urandom);
            for (int i = 0; i < NUM_CELLS; i++) v[i*DATA_W +: DATA_W] = 8'($urandom);
            run_req(b, v, int'($urandom_range(0, 2)), 1'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
